// File: rtl/bti_sram.sv
`default_nettype none
// =============================================================================
// bti_sram : byte-strobed single-port SRAM, valid/ready request/response, fixed latency -- rev 1.0
// =============================================================================
module bti_sram #(
   parameter int AW      = 15,
   parameter int DW      = 32,
   parameter int LATENCY = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_vld,
   output logic          req_rdy,
   input  logic [AW-1:0] req_addr,
   input  logic          req_write,
   input  logic [DW-1:0] req_wdata,
   input  logic [DW/8-1:0] req_wstrb,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err
);

   localparam int NB    = DW / 8;
   localparam int OW    = $clog2(NB);
   localparam int IW    = AW - OW;
   localparam int WORDS = (2 ** AW) / NB;
   localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      cnt, cnt_nxt;
   logic [DW-1:0]   data [WORDS];
   logic            accept;
   logic            aligned;
   logic [IW-1:0]   idx;

   assign req_rdy = (state == IDLE);
   assign rsp_vld = (state == RESP);
   assign accept  = req_vld && req_rdy;
   assign idx     = req_addr[AW-1:OW];
   assign aligned = (req_addr[OW-1:0] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == 3'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 3'd1;
         end
         RESP: begin
            if (rsp_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Storage is never reset; writes are blocked while reset is held so contents survive it.
   always_ff @(posedge clk) begin
      if (rst_n && accept && aligned && req_write) begin
         for (int i = 0; i < NB; i++) begin
            if (req_wstrb[i]) data[idx][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         rsp_err   <= !aligned;
         rsp_rdata <= (aligned && !req_write) ? data[idx] : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bti_sram.sv
`default_nettype none
// =============================================================================
// tb_bti_sram : three bti_sram configurations checked against a byte-level memory model -- rev 1.0
// =============================================================================
module tb_bti_sram;

   localparam int N = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [N-1:0]      req_vld = '0;
   logic [N-1:0]      req_write = '0;
   logic [N-1:0]      rsp_rdy = '0;
   logic [14:0]       req_addr  [N];
   logic [63:0]       req_wdata [N];
   logic [7:0]        req_wstrb [N];
   wire  [N-1:0]      req_rdy;
   wire  [N-1:0]      rsp_vld;
   wire  [N-1:0]      rsp_err;
   wire  [31:0]       rdata0;
   wire  [31:0]       rdata1;
   wire  [63:0]       rdata2;

   int checks = 0;
   int errors = 0;

   // byte-addressed reference memory, keyed by instance and byte address
   logic [7:0] bmem [int];

   always #5 clk = ~clk;

   bti_sram #(.AW(15), .DW(32), .LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld[0]), .req_rdy(req_rdy[0]), .req_addr(req_addr[0][14:0]),
      .req_write(req_write[0]), .req_wdata(req_wdata[0][31:0]), .req_wstrb(req_wstrb[0][3:0]),
      .rsp_vld(rsp_vld[0]), .rsp_rdy(rsp_rdy[0]), .rsp_rdata(rdata0), .rsp_err(rsp_err[0])
   );

   bti_sram #(.AW(15), .DW(32), .LATENCY(4)) u_l4 (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld[1]), .req_rdy(req_rdy[1]), .req_addr(req_addr[1][14:0]),
      .req_write(req_write[1]), .req_wdata(req_wdata[1][31:0]), .req_wstrb(req_wstrb[1][3:0]),
      .rsp_vld(rsp_vld[1]), .rsp_rdy(rsp_rdy[1]), .rsp_rdata(rdata1), .rsp_err(rsp_err[1])
   );

   bti_sram #(.AW(12), .DW(64), .LATENCY(2)) u_w64 (
      .clk(clk), .rst_n(rst_n),
      .req_vld(req_vld[2]), .req_rdy(req_rdy[2]), .req_addr(req_addr[2][11:0]),
      .req_write(req_write[2]), .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
      .rsp_vld(rsp_vld[2]), .rsp_rdy(rsp_rdy[2]), .rsp_rdata(rdata2), .rsp_err(rsp_err[2])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 4 : 2;
   endfunction

   function automatic int nb_of(input int d);
      return (d == 2) ? 8 : 4;
   endfunction

   function automatic int aw_of(input int d);
      return (d == 2) ? 12 : 15;
   endfunction

   function automatic int key(input int d, input int a);
      return d * 65536 + a;
   endfunction

   function automatic logic [63:0] rdata_of(input int d);
      case (d)
         0:       return {32'b0, rdata0};
         1:       return {32'b0, rdata1};
         default: return rdata2;
      endcase
   endfunction

   // word slot k: the low words plus the two highest words of the array
   function automatic logic [14:0] waddr(input int d, input int k);
      int nb;
      nb = nb_of(d);
      if (k < 6) return 15'(k * nb);
      return 15'((1 << aw_of(d)) - (8 - k) * nb);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_write(input int d, input int a, input logic [63:0] wd, input logic [7:0] ws);
      for (int i = 0; i < nb_of(d); i++)
         if (ws[i]) bmem[key(d, a + i)] = wd[8*i +: 8];
   endtask

   function automatic logic [63:0] model_read(input int d, input int a);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < nb_of(d); i++)
         if (bmem.exists(key(d, a + i))) r[8*i +: 8] = bmem[key(d, a + i)];
      return r;
   endfunction

   task automatic wait_ready(input int d);
      int w;
      w = 0;
      while (req_rdy[d] !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check1($sformatf("d%0d_rdy_before_req", d), req_rdy[d], 1'b1);
   endtask

   task automatic drive_req(input int d, input bit wr, input logic [14:0] addr,
                            input logic [63:0] wd, input logic [7:0] ws);
      req_vld[d]   = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      req_wstrb[d] = ws;
      @(posedge clk);
      #1;
      // idle-side fields are scrambled; they must have no effect
      req_vld[d]   = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = 15'($urandom);
      req_wdata[d] = {$urandom, $urandom};
      req_wstrb[d] = 8'($urandom);
   endtask

   task automatic txn(input int d, input bit wr, input logic [14:0] addr,
                      input logic [63:0] wd, input logic [7:0] ws, input int stall);
      int          nb, lat, base;
      logic        exp_e;
      logic [63:0] exp_d;
      nb  = nb_of(d);
      lat = lat_of(d);
      wait_ready(d);
      drive_req(d, wr, addr, wd, ws);
      exp_e = (int'(addr) % nb) != 0;
      base  = int'(addr) - int'(addr) % nb;
      exp_d = '0;
      if (!exp_e && wr)  model_write(d, base, wd, ws);
      if (!exp_e && !wr) exp_d = model_read(d, base);
      for (int j = 1; j <= lat; j++) begin
         @(negedge clk);
         check1($sformatf("d%0d_vld_cyc%0d", d, j), rsp_vld[d], (j == lat));
         check1($sformatf("d%0d_rdy_busy_cyc%0d", d, j), req_rdy[d], 1'b0);
      end
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) begin
            @(negedge clk);
            check1($sformatf("d%0d_vld_hold%0d", d, s), rsp_vld[d], 1'b1);
            check1($sformatf("d%0d_rdy_hold%0d", d, s), req_rdy[d], 1'b0);
         end
         check($sformatf("d%0d_rdata_a%h", d, addr), rdata_of(d), exp_d);
         check1($sformatf("d%0d_err_a%h", d, addr), rsp_err[d], exp_e);
      end
      rsp_rdy[d] = 1'b1;
      @(negedge clk);
      rsp_rdy[d] = 1'b0;
      check1($sformatf("d%0d_vld_after_rdy", d), rsp_vld[d], 1'b0);
      check1($sformatf("d%0d_rdy_after_rdy", d), req_rdy[d], 1'b1);
   endtask

   task automatic rst_mid_wait(input int d, input bit wr, input logic [14:0] addr, input logic [63:0] wd);
      wait_ready(d);
      drive_req(d, wr, addr, wd, 8'hFF);
      if (wr) model_write(d, int'(addr), wd, 8'hFF);
      @(negedge clk);
      check1("rstw_vld_in_wait", rsp_vld[d], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check1("rstw_vld", rsp_vld[d], 1'b0);
      check1("rstw_rdy", req_rdy[d], 1'b1);
      check1("rstw_err", rsp_err[d], 1'b0);
      check("rstw_rdata", rdata_of(d), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check1($sformatf("rstw_no_rsp%0d", j), rsp_vld[d], 1'b0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          k;
      logic [14:0] a;
      for (int d = 0; d < N; d++) begin
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         req_wstrb[d] = '0;
      end

      // asynchronous reset, observed before the first clock edge
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < N; d++) begin
         check1($sformatf("rst_rdy_d%0d", d), req_rdy[d], 1'b1);
         check1($sformatf("rst_vld_d%0d", d), rsp_vld[d], 1'b0);
         check1($sformatf("rst_err_d%0d", d), rsp_err[d], 1'b0);
         check($sformatf("rst_rdata_d%0d", d), rdata_of(d), 64'h0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // LATENCY=1: full write, partial write, misaligned read, zero-strobe write
      txn(0, 1'b1, 15'h10, 64'hDEADBEEF, 8'hF, 0);
      txn(0, 1'b0, 15'h10, 64'h0, 8'h0, 0);
      check("l1_read_deadbeef", rdata_of(0), 64'hDEADBEEF);
      txn(0, 1'b1, 15'h10, 64'h000000AA, 8'h1, 0);
      txn(0, 1'b0, 15'h10, 64'h0, 8'h0, 0);
      check("l1_read_deadbeaa", rdata_of(0), 64'hDEADBEAA);
      txn(0, 1'b0, 15'h13, 64'h0, 8'h0, 0);
      txn(0, 1'b1, 15'h11, 64'h55555555, 8'hF, 1);
      txn(0, 1'b1, 15'h10, 64'h12121212, 8'h0, 0);
      txn(0, 1'b0, 15'h10, 64'h0, 8'h0, 0);
      check("l1_after_err_and_zero_strobe", rdata_of(0), 64'hDEADBEAA);

      // LATENCY=4 with a stalled response, then reset during WAIT
      txn(1, 1'b1, 15'h20, 64'hCAFEF00D, 8'hF, 3);
      txn(1, 1'b0, 15'h20, 64'h0, 8'h0, 3);
      rst_mid_wait(1, 1'b1, 15'h14, 64'h12345678);
      rst_mid_wait(1, 1'b0, 15'h14, 64'h0);
      txn(1, 1'b0, 15'h14, 64'h0, 8'h0, 0);
      check("l4_survives_reset", rdata_of(1), 64'h12345678);

      // DW=64: upper-half strobe over prior contents, misaligned access
      txn(2, 1'b1, 15'h8, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 0);
      txn(2, 1'b1, 15'h8, 64'h11223344_55667788, 8'hF0, 0);
      txn(2, 1'b0, 15'h8, 64'h0, 8'h0, 2);
      check("w64_upper_merge", rdata_of(2), 64'h11223344_5A5A5A5A);
      txn(2, 1'b0, 15'hC, 64'h0, 8'h0, 0);

      // randomized traffic over a small set of word slots, including the top of the array
      for (int d = 0; d < N; d++) begin
         for (int s = 0; s < 8; s++) txn(d, 1'b1, waddr(d, s), {$urandom, $urandom}, 8'hFF, 0);
         for (int t = 0; t < 30; t++) begin
            k = $urandom_range(0, 7);
            a = waddr(d, k);
            if ($urandom_range(0, 3) == 0) a = a + 15'($urandom_range(1, nb_of(d) - 1));
            txn(d, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
                $urandom_range(0, 2));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bti_sram.md
BTI_SRAM -- requirements
Module: bti_sram

Interface
REQ-001 Parameter AW, default 15: byte-address width; array depth SHALL be 2^AW/(DW/8) words.
REQ-002 Parameter DW, default 32: data width, one of 32 or 64.
REQ-003 Parameter LATENCY, default 1: cycles from request acceptance to rsp_vld, legal range 1..8.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_vld  input  1  request valid.
REQ-007 req_rdy  output  1  request ready.
REQ-008 req_addr  input  AW  byte address.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_wdata  input  DW  write data.
REQ-011 req_wstrb  input  DW/8  byte-lane write enables.
REQ-012 rsp_vld  output  1  response valid.
REQ-013 rsp_rdy  input  1  response ready.
REQ-014 rsp_rdata  output  DW  read data.
REQ-015 rsp_err  output  1  response error flag.

Function
REQ-016 States SHALL be IDLE, WAIT and RESP.
REQ-017 req_rdy SHALL be 1 exactly when the state is IDLE.
REQ-018 A request is accepted on an edge where req_vld && req_rdy.
REQ-019 Word index SHALL be req_addr[AW-1:log2(DW/8)].
REQ-020 An address is misaligned when req_addr[log2(DW/8)-1:0] != 0.
REQ-021 Accepted aligned write: at the accept edge, for each lane i with req_wstrb[i]=1, byte i of the word SHALL be written; lanes with req_wstrb[i]=0 SHALL be unchanged.
REQ-022 Accepted aligned read: the addressed word SHALL be captured into a response register at the accept edge.
REQ-023 Accepted misaligned request: the array SHALL NOT be modified, and the captured rsp_err SHALL be 1.
REQ-024 rsp_rdata SHALL be 0 for write responses and for error responses.
REQ-025 LATENCY=1: IDLE SHALL go directly to RESP, so rsp_vld is 1 in the cycle after acceptance.
REQ-026 LATENCY>1: IDLE SHALL go to WAIT and load a counter with LATENCY-2.
REQ-027 In WAIT the counter SHALL decrement each cycle, and WAIT SHALL go to RESP on the edge where the counter is 0.
REQ-028 As a result of REQ-025..REQ-027, rsp_vld SHALL rise exactly LATENCY cycles after the accept edge.
REQ-029 In RESP, rsp_vld SHALL be 1.
REQ-030 In RESP, rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_rdy=1; that edge SHALL return the state to IDLE.
REQ-031 Throughput SHALL be at most one transaction per LATENCY+1 cycles; only one transaction is outstanding.
REQ-032 req_wdata, req_wstrb, req_addr and req_write SHALL be ignored when no request is accepted.
REQ-033 A write with req_wstrb=0 SHALL complete normally with rsp_err=0 and no array change.
REQ-034 Back-to-back same-address write then read SHALL return the written data, since the write commits before the read is accepted.

Reset
REQ-035 Reset assertion SHALL take effect immediately, independent of clk.
REQ-036 During reset: state=IDLE, counter=0, rsp_vld=0, rsp_err=0, rsp_rdata=0, req_rdy=1.
REQ-037 Array contents SHALL NOT be reset; they survive reset and may be preloaded by hierarchical $readmemh on the array member named data.
REQ-038 Reset asserted in WAIT or RESP SHALL discard the pending response with no rsp_vld pulse.
REQ-039 A write accepted before reset SHALL remain committed after reset.

Verification
REQ-040 LATENCY=1: write addr 0x10 wdata 0xDEADBEEF wstrb 0xF, then read 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_vld 1 cycle after each accept.
REQ-041 Partial write 0x10 wdata 0x000000AA wstrb 0x1 over 0xDEADBEEF, then read -> 0xDEADBEAA.
REQ-042 Read 0x13 -> rsp_err 1, rsp_rdata 0; subsequent read 0x10 shows the word unchanged.
REQ-043 LATENCY=4, rsp_rdy held 0 for 3 cycles -> rsp_vld rises 4 cycles after accept, and data and error are stable until the rsp_rdy edge; req_rdy stays 0 until the state returns to IDLE.
REQ-044 Preload word 5 = 0x12345678 via $readmemh, pulse rst_n low mid-WAIT -> no response; after reset, read 0x14 -> 0x12345678.
REQ-045 DW=64, AW=12: write 0x8 wstrb 0xF0 data 0x1122334455667788, then read 0x8 -> 0x11223344 in the upper half, prior contents in the lower half.
